// File: rtl/alu_share_arb.sv
// alu_share_arb: one RV32 integer ALU shared by two valid/ready requesters.
// Each cycle one request is granted. The ALU evaluates it combinationally in
// stage p0. The tagged result is held in a single output register (stage p1)
// until the consumer takes it. Latency is one cycle, and throughput is one op
// per cycle while the consumer does not stall.
// Optional macro ALU_ARB_RR_EN: round-robin arbitration through a 1-bit
// `last` pointer. When the macro is undefined, req0 has fixed priority over req1.
module alu_share_arb (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req0_vld,
  output logic        o_req0_rdy,
  input  logic [3:0]  i_req0_op,
  input  logic [31:0] i_req0_a,
  input  logic [31:0] i_req0_b,
  input  logic        i_req1_vld,
  output logic        o_req1_rdy,
  input  logic [3:0]  i_req1_op,
  input  logic [31:0] i_req1_a,
  input  logic [31:0] i_req1_b,
  output logic        o_rsp_vld,
  input  logic        i_rsp_rdy,
  output logic        o_rsp_id,
  output logic [31:0] o_rsp_data,
  output logic        o_rsp_err
);

  localparam int DATA_W = 32;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_SLT  = 4'h2;
  localparam logic [3:0] OP_SLTU = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_SLL  = 4'h7;
  localparam logic [3:0] OP_SRL  = 4'h8;
  localparam logic [3:0] OP_SRA  = 4'h9;
  localparam logic [3:0] OP_LUI  = 4'hA;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} rsp_state_t;

  // ALU evaluation. It returns {err, result}. An undefined op yields 0 with err set.
  function automatic logic [DATA_W:0] alu_eval(input logic [3:0]        op,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] sa;
    logic signed [DATA_W-1:0] sb;
    logic        [DATA_W-1:0] r;
    logic                     err;
    sa  = a;
    sb  = b;
    r   = '0;
    err = 1'b0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a + ~b + 32'd1;
      OP_SLT:  r = {31'b0, (sa < sb)};
      OP_SLTU: r = {31'b0, (a < b)};
      OP_XOR:  r = a ^ b;
      OP_OR:   r = a | b;
      OP_AND:  r = a & b;
      OP_SLL:  r = a << b[4:0];
      OP_SRL:  r = a >> b[4:0];
      OP_SRA:  r = $unsigned(sa >>> b[4:0]);
      OP_LUI:  r = b;
      default: err = 1'b1;
    endcase
    return {err, r};
  endfunction

  logic              grant0;
  logic              grant1;
  logic              can_acc;
  logic              acc_p0;
  logic              xfer_p1;
  logic [3:0]        op_p0;
  logic [DATA_W-1:0] a_p0;
  logic [DATA_W-1:0] b_p0;
  logic [DATA_W:0]   alu_p0;
  rsp_state_t        state_p1;
  rsp_state_t        state_nxt;
  logic              id_p1;
  logic [DATA_W-1:0] data_p1;
  logic              err_p1;

`ifdef ALU_ARB_RR_EN
  logic last;

  // Round-robin grant: on a tie the requester that was not served last wins.
  always_comb begin
    grant0 = i_req0_vld & (~i_req1_vld | last);
    grant1 = i_req1_vld & (~i_req0_vld | ~last);
  end

  // The last-served pointer moves only when a request is actually accepted.
  // Its reset value of 1 hands the first tie to req0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       last <= 1'b1;
    else if (acc_p0) last <= o_req1_rdy;
  end
`else
  // Fixed-priority grant: req0 always wins, so req1 can starve.
  always_comb begin
    grant0 = i_req0_vld;
    grant1 = i_req1_vld & ~i_req0_vld;
  end
`endif

  // Stage p0: select the granted request and evaluate it.
  always_comb begin
    op_p0  = grant1 ? i_req1_op : i_req0_op;
    a_p0   = grant1 ? i_req1_a  : i_req0_a;
    b_p0   = grant1 ? i_req1_b  : i_req0_b;
    alu_p0 = alu_eval(op_p0, a_p0, b_p0);
  end

  // Output register state: EMPTY or FULL.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_p1 <= EMPTY;
    else       state_p1 <= state_nxt;
  end

  // Next state: a load fills the register. A consume without a load drains it.
  always_comb begin
    state_nxt = state_p1;
    case (state_p1)
      EMPTY:   if (acc_p0) state_nxt = FULL;
      FULL:    if (xfer_p1 && !acc_p0) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // Handshake outputs. Ready depends only on the grant and the register space,
  // and never on a requester's own op or operands.
  always_comb begin
    o_rsp_vld  = (state_p1 == FULL);
    can_acc    = ~o_rsp_vld | i_rsp_rdy;
    xfer_p1    = o_rsp_vld & i_rsp_rdy;
    o_req0_rdy = grant0 & can_acc;
    o_req1_rdy = grant1 & can_acc;
    acc_p0     = (i_req0_vld & o_req0_rdy) | (i_req1_vld & o_req1_rdy);
  end

  // Stage p1: the result payload loads on every accept and holds otherwise.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      id_p1   <= 1'b0;
      data_p1 <= '0;
      err_p1  <= 1'b0;
    end else if (acc_p0) begin
      id_p1   <= o_req1_rdy;
      data_p1 <= alu_p0[DATA_W-1:0];
      err_p1  <= alu_p0[DATA_W];
    end
  end

  assign o_rsp_id   = id_p1;
  assign o_rsp_data = data_p1;
  assign o_rsp_err  = err_p1;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed testbench for alu_share_arb: a table of single-op vectors, then
// hand-written sequences for contention, backpressure and reset.
module tb_alu_share_arb;

  logic        clk;
  logic        rst;
  logic        req0_vld, req0_rdy;
  logic [3:0]  req0_op;
  logic [31:0] req0_a, req0_b;
  logic        req1_vld, req1_rdy;
  logic [3:0]  req1_op;
  logic [31:0] req1_a, req1_b;
  logic        rsp_vld, rsp_rdy, rsp_id, rsp_err;
  logic [31:0] rsp_data;

  int n_cmp = 0;
  int n_bad = 0;

  alu_share_arb dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0_vld(req0_vld), .o_req0_rdy(req0_rdy), .i_req0_op(req0_op),
    .i_req0_a(req0_a), .i_req0_b(req0_b),
    .i_req1_vld(req1_vld), .o_req1_rdy(req1_rdy), .i_req1_op(req1_op),
    .i_req1_a(req1_a), .i_req1_b(req1_b),
    .o_rsp_vld(rsp_vld), .i_rsp_rdy(rsp_rdy), .o_rsp_id(rsp_id),
    .o_rsp_data(rsp_data), .o_rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rid;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] data;
    logic        err;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rid, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req0_vld = (rid == 1'b0);
    req1_vld = (rid == 1'b1);
    if (rid) begin req1_op = op; req1_a = a; req1_b = b; end
    else     begin req0_op = op; req0_a = a; req0_b = b; end
  endtask

  task automatic chk_rsp(input string name, input logic id, input logic [31:0] data, input logic err);
    chk({name, ".vld"},  {31'b0, rsp_vld}, 32'd1);
    chk({name, ".id"},   {31'b0, rsp_id},  {31'b0, id});
    chk({name, ".data"}, rsp_data,         data);
    chk({name, ".err"},  {31'b0, rsp_err}, {31'b0, err});
  endtask

  logic [0:0] exp_ids [4];
  logic [31:0] exp_hold;

  initial begin
    vecs[0]  = '{1'b0, 4'h0, 32'd5,        32'd7,        32'd12,       1'b0};
    vecs[1]  = '{1'b0, 4'h1, 32'd3,        32'd5,        32'hFFFFFFFE, 1'b0};
    vecs[2]  = '{1'b1, 4'h9, 32'h80000000, 32'h00000024, 32'hF8000000, 1'b0};
    vecs[3]  = '{1'b0, 4'h2, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0};
    vecs[4]  = '{1'b1, 4'h3, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0};
    vecs[5]  = '{1'b0, 4'h2, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0};
    vecs[6]  = '{1'b0, 4'h3, 32'd1,        32'hFFFFFFFF, 32'd1,        1'b0};
    vecs[7]  = '{1'b1, 4'h4, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0};
    vecs[8]  = '{1'b0, 4'h5, 32'h0000F00F, 32'h00FF0000, 32'h00FFF00F, 1'b0};
    vecs[9]  = '{1'b0, 4'h6, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0};
    vecs[10] = '{1'b1, 4'h7, 32'd1,        32'h0000003F, 32'h80000000, 1'b0};
    vecs[11] = '{1'b0, 4'h8, 32'h80000000, 32'd4,        32'h08000000, 1'b0};
    vecs[12] = '{1'b0, 4'h9, 32'h40000000, 32'd1,        32'h20000000, 1'b0};
    vecs[13] = '{1'b0, 4'hA, 32'h00001234, 32'hABCDE000, 32'hABCDE000, 1'b0};
    vecs[14] = '{1'b0, 4'h0, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0};
    vecs[15] = '{1'b0, 4'hC, 32'd1,        32'd1,        32'd0,        1'b1};
    vecs[16] = '{1'b1, 4'hF, 32'd9,        32'd9,        32'd0,        1'b1};

    rst = 1'b1; rsp_rdy = 1'b0;
    req0_vld = 1'b1; req0_op = 4'h0; req0_a = 32'd1; req0_b = 32'd1;
    req1_vld = 1'b0; req1_op = 4'h0; req1_a = 32'd0; req1_b = 32'd0;

    // Reset values; a request offered during reset sees rdy but is not taken.
    #2;
    chk("rst.vld",  {31'b0, rsp_vld}, 32'd0);
    chk("rst.data", rsp_data,         32'd0);
    chk("rst.id",   {31'b0, rsp_id},  32'd0);
    chk("rst.err",  {31'b0, rsp_err}, 32'd0);
    chk("rst.rdy0", {31'b0, req0_rdy}, 32'd1);
    chk("rst.rdy1", {31'b0, req1_rdy}, 32'd0);
    step();
    chk("rst.noacc", {31'b0, rsp_vld}, 32'd0);
    req0_vld = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    rsp_rdy = 1'b1;

    // Back-to-back single ops with the consumer always ready.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rid, vecs[i].op, vecs[i].a, vecs[i].b);
      #1;
      chk($sformatf("vec%0d.rdy0", i), {31'b0, req0_rdy}, {31'b0, ~vecs[i].rid});
      chk($sformatf("vec%0d.rdy1", i), {31'b0, req1_rdy}, {31'b0, vecs[i].rid});
      step();
      chk_rsp($sformatf("vec%0d", i), vecs[i].rid, vecs[i].data, vecs[i].err);
    end
    req0_vld = 1'b0; req1_vld = 1'b0;
    step();
    chk("drain.vld", {31'b0, rsp_vld}, 32'd0);

    // Contention: both requesters valid for four cycles.
`ifdef ALU_ARB_RR_EN
    exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_ids = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    drive(1'b0, 4'h0, 32'd100, 32'd0);
    req1_vld = 1'b1; req1_op = 4'h0; req1_a = 32'd200; req1_b = 32'd0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("cont%0d.rdy0", k), {31'b0, req0_rdy}, {31'b0, ~exp_ids[k]});
      chk($sformatf("cont%0d.rdy1", k), {31'b0, req1_rdy}, {31'b0, exp_ids[k]});
      step();
      chk_rsp($sformatf("cont%0d", k), exp_ids[k][0], exp_ids[k][0] ? 32'd200 : 32'd100, 1'b0);
    end
    req0_vld = 1'b0; req1_vld = 1'b0;
    step();

    // Backpressure: fill while the consumer stalls, then hold for three cycles.
    rsp_rdy = 1'b0;
    drive(1'b0, 4'h0, 32'd10, 32'd20);
    step();
    chk_rsp("bp.load", 1'b0, 32'd30, 1'b0);
    drive(1'b1, 4'h1, 32'd50, 32'd8);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp%0d.rdy0", k), {31'b0, req0_rdy}, 32'd0);
      chk($sformatf("bp%0d.rdy1", k), {31'b0, req1_rdy}, 32'd0);
      step();
      chk_rsp($sformatf("bp%0d", k), 1'b0, 32'd30, 1'b0);
    end
    rsp_rdy = 1'b1;
    #1;
    chk("bp.rel.rdy1", {31'b0, req1_rdy}, 32'd1);
    step();
    chk_rsp("bp.nobubble", 1'b1, 32'd42, 1'b0);

    // Reset while FULL and stalled; the last winner before reset is req0.
    drive(1'b0, 4'h0, 32'd1, 32'd1);
    step();
    chk_rsp("rr.pre", 1'b0, 32'd2, 1'b0);
    req0_vld = 1'b0;
    rsp_rdy = 1'b0;
    step();
    exp_hold = 32'd2;
    chk("pre.hold", rsp_data, exp_hold);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.vld",  {31'b0, rsp_vld}, 32'd0);
    chk("arst.data", rsp_data,         32'd0);
    req0_vld = 1'b1; req0_op = 4'h0; req0_a = 32'd7; req0_b = 32'd8;
    req1_vld = 1'b1; req1_op = 4'h0; req1_a = 32'd9; req1_b = 32'd9;
    #1;
    chk("arst.rdy0", {31'b0, req0_rdy}, 32'd1);
    chk("arst.rdy1", {31'b0, req1_rdy}, 32'd0);
    step();
    chk("arst.noacc", {31'b0, rsp_vld}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rsp_rdy = 1'b1;
    step();
    chk_rsp("post.tie0", 1'b0, 32'd15, 1'b0);
    step();
`ifdef ALU_ARB_RR_EN
    chk_rsp("post.tie1", 1'b1, 32'd18, 1'b0);
`else
    chk_rsp("post.tie1", 1'b0, 32'd15, 1'b0);
`endif
    req0_vld = 1'b0; req1_vld = 1'b0;
    step();
    chk("end.vld", {31'b0, rsp_vld}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Shares one RV32 integer ALU datapath between two requesters (e.g. the execute stage and a multi-cycle address/CSR helper) with valid/ready handshakes. It arbitrates each cycle, evaluates the granted operation, and holds the tagged result in a single output register until the consumer accepts it. It sits between the requesters and writeback, with one cycle of latency and full throughput when the consumer does not stall.

## Interface
- Parameters: none; data width is fixed at 32, op code width at 4.
- `i_clk` input 1: clock, rising edge.
- `i_rst` input 1: reset, asynchronous, active-high.
- `i_req0_vld` input 1: requester 0 has a valid operation.
- `o_req0_rdy` output 1: requester 0 operation accepted this cycle.
- `i_req0_op` input 4: ALU op code (ADD=0 SUB=1 SLT=2 SLTU=3 XOR=4 OR=5 AND=6 SLL=7 SRL=8 SRA=9 LUI=A).
- `i_req0_a` input 32: operand A.
- `i_req0_b` input 32: operand B.
- `i_req1_vld`, `o_req1_rdy`, `i_req1_op`, `i_req1_a`, `i_req1_b`: same as requester 0, for requester 1.
- `o_rsp_vld` output 1: result register holds a valid result.
- `i_rsp_rdy` input 1: consumer accepts the result.
- `o_rsp_id` output 1: requester that issued the result.
- `o_rsp_data` output 32: result.
- `o_rsp_err` output 1: op code was undefined (B–F).

## Operation
- Clock and reset: one clock; reset is asynchronous and active-high.
- Transfers: a request transfers when vld & rdy. A response transfers when `o_rsp_vld` & `i_rsp_rdy`.
- Accept condition: `can_acc = !o_rsp_vld | i_rsp_rdy`.
- Ready: `o_reqN_rdy = grantN & can_acc`. Ready may depend on the other requester's vld. Ready never depends on the requester's own op or data.
- Grant, fixed priority (no macro): req0 always wins when both are valid.
- Grant, round-robin (with macro):
  - A 1-bit `last` pointer records the last accepted requester.
  - On a tie, the requester that is not `last` wins.
  - A single valid requester is always granted.
  - `last` updates only on an accepted transfer.
- Requester rule: while vld & !rdy, the requester must hold op and operands stable and must not drop vld.
- Datapath functions, evaluated on the granted request:
  - ADD: a+b, wrapping mod 2^32.
  - SUB: a+~b+1, wrapping.
  - SLT: signed compare, result is {31'b0, a<b}.
  - SLTU: unsigned compare.
  - XOR, OR, AND: bitwise.
  - SLL, SRL, SRA: shift amount is b[4:0]; b[31:5] is ignored; SRA replicates a[31].
  - LUI: result = b.
- Undefined op (B–F): result 0, `o_rsp_err`=1, accepted normally.
- Output register states:
  - EMPTY (`o_rsp_vld`=0): loads on accept.
  - FULL: holds data, id and err stable until the response transfer.
  - On a response transfer with a simultaneous accept, it reloads with the new result and stays FULL.
  - On a response transfer without an accept, it goes EMPTY.

## Timing
- Reset values: `o_rsp_vld`=0, `o_rsp_data`=0, `o_rsp_id`=0, `o_rsp_err`=0, `last`=1 (so req0 wins the first tie). `o_reqN_rdy` is combinational; while reset is asserted it equals `grantN`, because the register is EMPTY.
- Latency: a request accepted at edge N gives `o_rsp_vld`=1 with its result after edge N.
- Throughput: one op per cycle while `i_rsp_rdy`=1.
- Stall: with FULL and `i_rsp_rdy`=0, both rdy are 0 and nothing changes.
- Reset mid-operation: asserting `i_rsp_rdy`… no; asserting `i_rst` asynchronously clears the output register and `last`. An unconsumed result is dropped. A request presented during reset is not accepted.
- Simultaneous events:
  - Same-cycle consume and accept is legal and causes no bubble.
  - Both requesters valid: exactly one is accepted; the other sees rdy=0.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin arbitration using the `last` pointer. Neither requester is starved; under continuous contention they alternate 0,1,0,1.
- `ALU_ARB_RR_EN` undefined: fixed priority, req0 over req1. The `last` register is not built. Req1 can starve.

## Test plan
- ADD: req0 op=0 a=5 b=7, `i_rsp_rdy`=1 → one cycle later `o_rsp_vld`=1, data=12, id=0, err=0.
- SUB and SRA:
  - SUB a=3 b=5 → 0xFFFFFFFE.
  - SRA a=0x80000000 b=0x24 (amount 4) → 0xF8000000.
  - SLT a=0xFFFFFFFF b=1 → 1; SLTU with the same operands → 0.
- Contention: both requesters valid for 4 cycles, `i_rsp_rdy`=1.
  - With `ALU_ARB_RR_EN`: ids 0,1,0,1.
  - Without it: ids 0,0,0,0, and req1 rdy stays 0.
- Backpressure:
  - Result FULL, `i_rsp_rdy`=0 for 3 cycles → data, id and err stable; both rdy=0.
  - Raise `i_rsp_rdy` with req1 pending → consume and accept in the same cycle; the next result appears with no bubble.
- Undefined op: op=0xC, a=1, b=1 → data=0, err=1; the request is accepted in the normal way.
- Reset mid-operation: assert `i_rst` while FULL and stalled → `o_rsp_vld` drops to 0 immediately (asynchronously). After release, the first tie is granted to req0.
